ai_master_rd_dispatcher: RTL and testbench

- Per-master read-side dispatcher, placed between one AXI4 master port and the SLV_AMT slave-arbitration blocks of the interconnect.
- Decodes the slave index from ARADDR and steers the AR request to the addressed slave arbiter.
- Tracks outstanding read bursts in an in-order slave-index FIFO and returns R beats to the master strictly in AR-issue order.
- Drives the outstanding-full flag that each slave arbiter uses to mask this master.

---
 rtl/ai_master_rd_dispatcher_pkg.sv | 15 +
 rtl/ai_master_rd_dispatcher_sync_fifo.sv | 53 +++++
 rtl/ai_master_rd_dispatcher.sv | 113 +++++++++++
 tb/tb_ai_master_rd_dispatcher.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ai_master_rd_dispatcher_pkg.sv
// rtl/ai_master_rd_dispatcher_pkg.sv - shared AXI widths and slave-index decode field for the read dispatcher
package ai_master_rd_dispatcher_pkg;

    localparam int DEF_SLV_AMT           = 2;
    localparam int DEF_OUTSTANDING_AMT   = 8;
    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_ADDR_WIDTH        = 32;
    localparam int DEF_TRANS_MST_ID_W    = 5;
    localparam int DEF_TRANS_BURST_W     = 2;
    localparam int DEF_TRANS_DATA_LEN_W  = 3;
    localparam int DEF_TRANS_DATA_SIZE_W = 3;
    localparam int DEF_SLV_ID_MSB_IDX    = 30;
    localparam int DEF_SLV_ID_LSB_IDX    = 30;

endpackage

// File: rtl/ai_master_rd_dispatcher_sync_fifo.sv
// rtl/ai_master_rd_dispatcher_sync_fifo.sv - ai_sync_fifo, parameterised synchronous FIFO with full/empty/count
module ai_sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Writes are refused while full even if a read happens in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ai_master_rd_dispatcher.sv
// rtl/ai_master_rd_dispatcher.sv - steers master AR to a slave arbiter and returns R beats in AR-issue order
module ai_master_rd_dispatcher
    import ai_master_rd_dispatcher_pkg::*;
#(
    parameter int SLV_AMT           = DEF_SLV_AMT,
    parameter int SLV_ID_W          = $clog2(SLV_AMT),
    parameter int OUTSTANDING_AMT   = DEF_OUTSTANDING_AMT,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int TRANS_MST_ID_W    = DEF_TRANS_MST_ID_W,
    parameter int TRANS_BURST_W     = DEF_TRANS_BURST_W,
    parameter int TRANS_DATA_LEN_W  = DEF_TRANS_DATA_LEN_W,
    parameter int TRANS_DATA_SIZE_W = DEF_TRANS_DATA_SIZE_W,
    parameter int SLV_ID_MSB_IDX    = DEF_SLV_ID_MSB_IDX,
    parameter int SLV_ID_LSB_IDX    = DEF_SLV_ID_LSB_IDX
) (
    input  logic                             ACLK_i,
    input  logic                             ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]        m_ARID_i,
    input  logic [ADDR_WIDTH-1:0]            m_ARADDR_i,
    input  logic [TRANS_BURST_W-1:0]         m_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]      m_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]     m_ARSIZE_i,
    input  logic                             m_ARVALID_i,
    output logic                             m_ARREADY_o,
    output logic [TRANS_MST_ID_W-1:0]        m_RID_o,
    output logic [DATA_WIDTH-1:0]            m_RDATA_o,
    output logic                             m_RLAST_o,
    output logic                             m_RVALID_o,
    input  logic                             m_RREADY_i,
    output logic [TRANS_MST_ID_W-1:0]        sa_ARID_o,
    output logic [ADDR_WIDTH-1:0]            sa_ARADDR_o,
    output logic [TRANS_BURST_W-1:0]         sa_ARBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]      sa_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]     sa_ARSIZE_o,
    output logic [SLV_AMT-1:0]               sa_ARVALID_o,
    input  logic [SLV_AMT-1:0]               sa_ARREADY_i,
    output logic                             sa_AR_outst_full_o,
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0] sa_RID_i,
    input  logic [DATA_WIDTH*SLV_AMT-1:0]    sa_RDATA_i,
    input  logic [SLV_AMT-1:0]               sa_RLAST_i,
    input  logic [SLV_AMT-1:0]               sa_RVALID_i,
    output logic [SLV_AMT-1:0]               sa_RREADY_o
);

    localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

    logic [SLV_ID_W-1:0] sel;
    logic [SLV_ID_W-1:0] head;
    logic                full;
    logic                empty;
    logic                fifo_full;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                pop;

    assign sel  = m_ARADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
    assign full = (fifo_count == CNT_W'(OUTSTANDING_AMT));

    assign sa_AR_outst_full_o = full;
    assign sa_ARID_o          = m_ARID_i;
    assign sa_ARADDR_o        = m_ARADDR_i;
    assign sa_ARBURST_o       = m_ARBURST_i;
    assign sa_ARLEN_o         = m_ARLEN_i;
    assign sa_ARSIZE_o        = m_ARSIZE_i;

    // ARREADY depends only on the addressed slave and our own fill level, never on ARVALID.
    assign m_ARREADY_o = sa_ARREADY_i[sel] & ~full;

    always_comb begin
        sa_ARVALID_o = '0;
        for (int s = 0; s < SLV_AMT; s++) begin
            sa_ARVALID_o[s] = m_ARVALID_i & (sel == SLV_ID_W'(s)) & ~full;
        end
    end

    // Only the slave at the head of the order FIFO may hand beats to the master.
    always_comb begin
        m_RVALID_o  = 1'b0;
        m_RID_o     = '0;
        m_RDATA_o   = '0;
        m_RLAST_o   = 1'b0;
        sa_RREADY_o = '0;
        for (int s = 0; s < SLV_AMT; s++) begin
            if (!empty && (head == SLV_ID_W'(s))) begin
                m_RVALID_o     = sa_RVALID_i[s];
                m_RID_o        = sa_RID_i[s*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                m_RDATA_o      = sa_RDATA_i[s*DATA_WIDTH +: DATA_WIDTH];
                m_RLAST_o      = sa_RLAST_i[s];
                sa_RREADY_o[s] = m_RREADY_i;
            end
        end
    end

    assign push = m_ARVALID_i & m_ARREADY_o;
    assign pop  = m_RVALID_o & m_RREADY_i & m_RLAST_o;

    ai_sync_fifo #(
        .WIDTH (SLV_ID_W),
        .DEPTH (OUTSTANDING_AMT)
    ) u_order_fifo (
        .clk     (ACLK_i),
        .rst_n   (ARESETn_i),
        .wr_en   (push & ~fifo_full),
        .wr_data (sel),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_ai_master_rd_dispatcher.sv
// tb/tb_ai_master_rd_dispatcher.sv - scoreboard bench for ai_master_rd_dispatcher
module tb_ai_master_rd_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  m_arid = '0;
    logic [31:0] m_araddr = '0;
    logic [1:0]  m_arburst = '0;
    logic [2:0]  m_arlen = '0;
    logic [2:0]  m_arsize = '0;
    logic        m_arvalid = 1'b0;
    logic        m_arready;
    logic [4:0]  m_rid;
    logic [31:0] m_rdata;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready = 1'b0;
    logic [4:0]  sa_arid;
    logic [31:0] sa_araddr;
    logic [1:0]  sa_arburst;
    logic [2:0]  sa_arlen;
    logic [2:0]  sa_arsize;
    logic [1:0]  sa_arvalid;
    logic [1:0]  sa_arready = '0;
    logic        sa_full;
    logic [9:0]  sa_rid = '0;
    logic [63:0] sa_rdata = '0;
    logic [1:0]  sa_rlast = '0;
    logic [1:0]  sa_rvalid = '0;
    logic [1:0]  sa_rready;

    int total = 0;
    int bad = 0;
    logic [37:0] exp_q [$];

    localparam logic [31:0] S0 = 32'h0000_0000;
    localparam logic [31:0] S1 = 32'h4000_0000;

    always #5 clk = ~clk;

    ai_master_rd_dispatcher dut (
        .ACLK_i             (clk),
        .ARESETn_i          (rst_n),
        .m_ARID_i           (m_arid),
        .m_ARADDR_i         (m_araddr),
        .m_ARBURST_i        (m_arburst),
        .m_ARLEN_i          (m_arlen),
        .m_ARSIZE_i         (m_arsize),
        .m_ARVALID_i        (m_arvalid),
        .m_ARREADY_o        (m_arready),
        .m_RID_o            (m_rid),
        .m_RDATA_o          (m_rdata),
        .m_RLAST_o          (m_rlast),
        .m_RVALID_o         (m_rvalid),
        .m_RREADY_i         (m_rready),
        .sa_ARID_o          (sa_arid),
        .sa_ARADDR_o        (sa_araddr),
        .sa_ARBURST_o       (sa_arburst),
        .sa_ARLEN_o         (sa_arlen),
        .sa_ARSIZE_o        (sa_arsize),
        .sa_ARVALID_o       (sa_arvalid),
        .sa_ARREADY_i       (sa_arready),
        .sa_AR_outst_full_o (sa_full),
        .sa_RID_i           (sa_rid),
        .sa_RDATA_i         (sa_rdata),
        .sa_RLAST_i         (sa_rlast),
        .sa_RVALID_i        (sa_rvalid),
        .sa_RREADY_o        (sa_rready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_rvalid && m_rready) begin
            if (exp_q.size() == 0) begin
                chk("r_unexpected_beat", {m_rid, m_rdata, m_rlast}, 38'h0);
            end else begin
                chk("r_beat", {26'h0, m_rid, m_rdata, m_rlast}, {26'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [4:0] id,
                            input logic [2:0] len, input logic [1:0] exp_vld);
        m_araddr  = addr;
        m_arid    = id;
        m_arlen   = len;
        m_arburst = 2'b01;
        m_arsize  = 3'd2;
        m_arvalid = 1'b1;
        #3;
        chk("ar_valid_steer", {62'h0, sa_arvalid}, {62'h0, exp_vld});
        chk("ar_ready", {63'h0, m_arready}, 64'h1);
        chk("ar_addr_pass", {32'h0, sa_araddr}, {32'h0, addr});
        tick;
        m_arvalid = 1'b0;
    endtask

    task automatic drive_r(input int s, input logic [4:0] id, input logic [31:0] data, input logic last);
        sa_rvalid[s]          = 1'b1;
        sa_rid[s*5 +: 5]      = id;
        sa_rdata[s*32 +: 32]  = data;
        sa_rlast[s]           = last;
    endtask

    task automatic r_beat(input int s, input logic [4:0] id, input logic [31:0] data, input logic last);
        sa_rvalid = '0;
        drive_r(s, id, data, last);
        m_rready = 1'b1;
        exp_q.push_back({id, data, last});
        #3;
        chk("r_valid_fwd", {63'h0, m_rvalid}, 64'h1);
        chk("r_ready_head", {62'h0, sa_rready}, 64'h1 << s);
        tick;
        sa_rvalid = '0;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_arready", {63'h0, m_arready}, 64'h0);
        chk("rst_rvalid", {63'h0, m_rvalid}, 64'h0);
        chk("rst_arvalid", {62'h0, sa_arvalid}, 64'h0);
        chk("rst_rready", {62'h0, sa_rready}, 64'h0);
        chk("rst_full", {63'h0, sa_full}, 64'h0);
        #4 rst_n = 1'b1;
        tick;
        sa_arready = 2'b11;

        // single AR to slave 1, four beats
        ar_issue(S1, 5'd5, 3'd3, 2'b10);
        chk("t1_count1", {60'h0, dut.fifo_count}, 64'd1);
        for (int i = 0; i < 4; i++) r_beat(1, 5'd5, 32'hA0 + i, i == 3);
        chk("t1_count0", {60'h0, dut.fifo_count}, 64'd0);

        // ordering: slave1 beat waits behind slave0 burst
        ar_issue(S0, 5'd1, 3'd1, 2'b01);
        ar_issue(S1, 5'd2, 3'd0, 2'b10);
        drive_r(1, 5'd2, 32'hB0, 1'b1);
        m_rready = 1'b1;
        #3;
        chk("t2_stall_rvalid", {63'h0, m_rvalid}, 64'h0);
        chk("t2_stall_rready", {62'h0, sa_rready}, 64'h1);
        tick;
        for (int i = 0; i < 2; i++) begin
            drive_r(0, 5'd1, 32'hC0 + i, i == 1);
            exp_q.push_back({5'd1, 32'hC0 + i, i == 1});
            #3;
            chk("t2_s0_rready", {62'h0, sa_rready}, 64'h1);
            tick;
        end
        sa_rvalid[0] = 1'b0;
        exp_q.push_back({5'd2, 32'hB0, 1'b1});
        #3;
        chk("t2_s1_rready", {62'h0, sa_rready}, 64'h2);
        tick;
        sa_rvalid = '0;
        m_rready  = 1'b0;
        chk("t2_count0", {60'h0, dut.fifo_count}, 64'd0);

        // fill to eight outstanding
        for (int i = 0; i < 8; i++)
            ar_issue((i % 2) ? S1 : S0, 5'(i), 3'd0, (i % 2) ? 2'b10 : 2'b01);
        chk("t3_count8", {60'h0, dut.fifo_count}, 64'd8);
        chk("t3_full", {63'h0, sa_full}, 64'h1);
        m_araddr = S0; m_arid = 5'd9; m_arlen = 3'd0; m_arvalid = 1'b1;
        #3;
        chk("t3_blk_arvalid", {62'h0, sa_arvalid}, 64'h0);
        chk("t3_blk_arready", {63'h0, m_arready}, 64'h0);
        tick;
        drive_r(0, 5'd0, 32'h300, 1'b1);
        m_rready = 1'b1;
        exp_q.push_back({5'd0, 32'h300, 1'b1});
        #3;
        chk("t3_no_bypass", {63'h0, m_arready}, 64'h0);
        tick;
        sa_rvalid = '0;
        #3;
        chk("t3_reaccept_rdy", {63'h0, m_arready}, 64'h1);
        chk("t3_reaccept_vld", {62'h0, sa_arvalid}, 64'h1);
        tick;
        m_arvalid = 1'b0;
        chk("t3_count8b", {60'h0, dut.fifo_count}, 64'd8);
        for (int i = 1; i < 6; i++) r_beat(i % 2, 5'(i), 32'h300 + i, 1'b1);
        chk("t4_count3", {60'h0, dut.fifo_count}, 64'd3);

        // simultaneous push and pop at count 3
        m_araddr = S1; m_arid = 5'd20; m_arlen = 3'd0; m_arvalid = 1'b1;
        drive_r(0, 5'd6, 32'h306, 1'b1);
        exp_q.push_back({5'd6, 32'h306, 1'b1});
        #3;
        chk("t4_ar_ready", {63'h0, m_arready}, 64'h1);
        chk("t4_r_valid", {63'h0, m_rvalid}, 64'h1);
        tick;
        m_arvalid = 1'b0;
        sa_rvalid = '0;
        chk("t4_count_hold", {60'h0, dut.fifo_count}, 64'd3);
        r_beat(1, 5'd7, 32'h307, 1'b1);
        r_beat(0, 5'd9, 32'h309, 1'b1);
        r_beat(1, 5'd20, 32'h320, 1'b1);
        chk("t4_count0", {60'h0, dut.fifo_count}, 64'd0);

        // back-pressure from the master
        ar_issue(S0, 5'd3, 3'd2, 2'b01);
        drive_r(0, 5'd3, 32'h500, 1'b0);
        m_rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("t5_bp_rready", {62'h0, sa_rready}, 64'h0);
            chk("t5_bp_rvalid", {63'h0, m_rvalid}, 64'h1);
            chk("t5_bp_rdata", {32'h0, m_rdata}, 64'h500);
            tick;
        end
        for (int i = 0; i < 3; i++) r_beat(0, 5'd3, 32'h500 + i, i == 2);
        chk("t5_count0", {60'h0, dut.fifo_count}, 64'd0);

        // async reset mid-burst
        ar_issue(S0, 5'd4, 3'd1, 2'b01);
        ar_issue(S1, 5'd5, 3'd0, 2'b10);
        chk("t6_count2", {60'h0, dut.fifo_count}, 64'd2);
        r_beat(0, 5'd4, 32'h600, 1'b0);
        m_rready   = 1'b0;
        sa_arready = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_count", {60'h0, dut.fifo_count}, 64'd0);
        chk("t6_rst_rvalid", {63'h0, m_rvalid}, 64'h0);
        chk("t6_rst_rready", {62'h0, sa_rready}, 64'h0);
        chk("t6_rst_arvalid", {62'h0, sa_arvalid}, 64'h0);
        chk("t6_rst_arready", {63'h0, m_arready}, 64'h0);
        chk("t6_rst_full", {63'h0, sa_full}, 64'h0);
        #4 rst_n = 1'b1;
        tick;
        sa_arready = 2'b11;
        ar_issue(S1, 5'd6, 3'd0, 2'b10);
        chk("t6_count1", {60'h0, dut.fifo_count}, 64'd1);
        r_beat(1, 5'd6, 32'h700, 1'b1);
        chk("t6_count0", {60'h0, dut.fifo_count}, 64'd0);

        tick;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
